// File: rtl/endec_axis_rx_packer.sv
// ---------------------------------------------------------------------------
// endec_axis_rx_packer
//
// AXI-Stream slave front end for the encoder/decoder core. The first beat of
// every packet is a config word. The payload beats that follow are packed
// MSB-first into either the encoder frame or the decoder frame. The finished
// frame and its config are then held for endec_interface until it takes them.
//
// Handshakes:
//   Upstream AXIS:   a beat transfers on a posedge where i_rx_tvalid and
//                    o_rx_tready are both 1.
//   Downstream:      the frame transfers on a posedge where o_frame_valid and
//                    i_frame_ready are both 1. i_frame_ready is ignored while
//                    no frame is held.
//
// Ports:
//   sys_clk, rst           clock and synchronous active-high reset
//   i_rx_tdata/tvalid/tlast, o_rx_tready   AXIS slave
//   o_code_rate            cfg bit 28
//   o_mode_sel             cfg bit 29 (0 = encode, 1 = decode)
//   o_gen_poly_flat        cfg bits POLY_W-1:0
//   o_enc_frame            packed encoder frame (4 beats)
//   o_dec_frame            packed decoder frame (12 beats)
//   o_frame_valid          frame + cfg complete and stable
//   i_frame_ready          downstream accepts the frame
//   o_err_short            1-cycle pulse: tlast before the frame filled
//   o_err_long             1-cycle pulse: frame filled without tlast
//   o_dbg_state            current FSM state (CFG=0, FILL=1, DRAIN=2, HOLD=3)
//
// Build option:
//   ENDEC_RX_BYTE_SWAP_EN  byte-reverse every accepted beat, the config beat
//                          included, before it is decoded or packed.
// ---------------------------------------------------------------------------
module endec_axis_rx_packer #(
    parameter int DATA_W      = 32,
    parameter int ENC_FRAME_W = 128,
    parameter int DEC_FRAME_W = 384,
    parameter int POLY_W      = 27
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      i_rx_tdata,
    input  logic                   i_rx_tvalid,
    input  logic                   i_rx_tlast,
    output logic                   o_rx_tready,
    output logic                   o_code_rate,
    output logic                   o_mode_sel,
    output logic [POLY_W-1:0]      o_gen_poly_flat,
    output logic [ENC_FRAME_W-1:0] o_enc_frame,
    output logic [DEC_FRAME_W-1:0] o_dec_frame,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ready,
    output logic                   o_err_short,
    output logic                   o_err_long,
    output logic [1:0]             o_dbg_state
);

    localparam int ENC_BEATS = ENC_FRAME_W / DATA_W;
    localparam int DEC_BEATS = DEC_FRAME_W / DATA_W;
    localparam logic [3:0] ENC_LAST = 4'(ENC_BEATS - 1);
    localparam logic [3:0] DEC_LAST = 4'(DEC_BEATS - 1);

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [DATA_W-1:0] beat;
    logic        accept;
    logic [3:0]  last_idx;
    logic        err_short_d;
    logic        err_long_d;

    assign accept      = i_rx_tvalid & o_rx_tready;
    assign last_idx    = o_mode_sel ? DEC_LAST : ENC_LAST;
    assign o_dbg_state = state_q;

`ifdef ENDEC_RX_BYTE_SWAP_EN
    always_comb begin
        beat = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            beat[8*b +: 8] = i_rx_tdata[DATA_W-8-8*b +: 8];
        end
    end
`else
    assign beat = i_rx_tdata;
`endif

    // Next-state and error-pulse decode.
    always_comb begin
        state_d     = state_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        case (state_q)
            ST_CFG: begin
                if (accept) begin
                    // A config-only packet still produces an (all-zero) frame.
                    state_d     = i_rx_tlast ? ST_HOLD : ST_FILL;
                    err_short_d = i_rx_tlast;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (cnt_q == last_idx) begin
                        state_d    = i_rx_tlast ? ST_HOLD : ST_DRAIN;
                        err_long_d = ~i_rx_tlast;
                    end else if (i_rx_tlast) begin
                        state_d     = ST_HOLD;
                        err_short_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && i_rx_tlast) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // o_frame_valid is always 1 while holding.
                if (i_frame_ready) begin
                    state_d = ST_CFG;
                end
            end
            default: state_d = ST_CFG;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q         <= ST_CFG;
            cnt_q           <= '0;
            o_rx_tready     <= 1'b0;
            o_code_rate     <= 1'b0;
            o_mode_sel      <= 1'b0;
            o_gen_poly_flat <= '0;
            o_enc_frame     <= '0;
            o_dec_frame     <= '0;
            o_frame_valid   <= 1'b0;
            o_err_short     <= 1'b0;
            o_err_long      <= 1'b0;
        end else begin
            state_q       <= state_d;
            // Ready and valid are registered copies of the next state.
            o_rx_tready   <= (state_d != ST_HOLD);
            o_frame_valid <= (state_d == ST_HOLD);
            o_err_short   <= err_short_d;
            o_err_long    <= err_long_d;

            if (state_q == ST_CFG && accept) begin
                o_gen_poly_flat <= beat[POLY_W-1:0];
                o_code_rate     <= beat[28];
                o_mode_sel      <= beat[29];
                cnt_q           <= '0;
                o_enc_frame     <= '0;
                o_dec_frame     <= '0;
            end

            if (state_q == ST_FILL && accept) begin
                if (!o_mode_sel) begin
                    for (int w = 0; w < ENC_BEATS; w++) begin
                        if (cnt_q == 4'(w)) begin
                            o_enc_frame[ENC_FRAME_W-1-DATA_W*w -: DATA_W] <= beat;
                        end
                    end
                end else begin
                    for (int w = 0; w < DEC_BEATS; w++) begin
                        if (cnt_q == 4'(w)) begin
                            o_dec_frame[DEC_FRAME_W-1-DATA_W*w -: DATA_W] <= beat;
                        end
                    end
                end
                // Saturate on the last word; the FSM leaves FILL there anyway.
                if (cnt_q != last_idx) begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_endec_axis_rx_packer.sv
// ---------------------------------------------------------------------------
// Testbench for endec_axis_rx_packer: directed packets (encode, decode,
// short, long, config-only, backpressure, mid-packet reset) followed by
// randomized packets with random gaps and random downstream ready.
// ---------------------------------------------------------------------------
module tb_endec_axis_rx_packer;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic [31:0]  i_rx_tdata;
    logic         i_rx_tvalid;
    logic         i_rx_tlast;
    logic         o_rx_tready;
    logic         o_code_rate;
    logic         o_mode_sel;
    logic [26:0]  o_gen_poly_flat;
    logic [127:0] o_enc_frame;
    logic [383:0] o_dec_frame;
    logic         o_frame_valid;
    logic         i_frame_ready;
    logic         o_err_short;
    logic         o_err_long;
    logic [1:0]   o_dbg_state;

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    endec_axis_rx_packer dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .i_rx_tdata      (i_rx_tdata),
        .i_rx_tvalid     (i_rx_tvalid),
        .i_rx_tlast      (i_rx_tlast),
        .o_rx_tready     (o_rx_tready),
        .o_code_rate     (o_code_rate),
        .o_mode_sel      (o_mode_sel),
        .o_gen_poly_flat (o_gen_poly_flat),
        .o_enc_frame     (o_enc_frame),
        .o_dec_frame     (o_dec_frame),
        .o_frame_valid   (o_frame_valid),
        .i_frame_ready   (i_frame_ready),
        .o_err_short     (o_err_short),
        .o_err_long      (o_err_long),
        .o_dbg_state     (o_dbg_state)
    );

    typedef struct packed {
        logic [383:0] dec;
        logic [127:0] enc;
        logic         rate;
        logic         mode;
        logic [26:0]  poly;
        logic         es;
        logic         el;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp;
    logic [31:0] pay_q[$];
    logic [31:0] cfg_v;
    int          checks = 0;
    int          errors = 0;
    int          gap_max = 0;
    logic        ready_rand = 1'b0;
    logic        ready_force = 1'b1;
    int          n_short = 0;
    int          n_long = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic report_and_finish();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] prep(input logic [31:0] d);
`ifdef ENDEC_RX_BYTE_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Reference model: whole-packet view. Keep the first N payload words
    // left-aligned in the selected frame; short/long is a length comparison.
    task automatic build_expect();
        exp_t        e;
        logic [31:0] c;
        int          n;
        c      = prep(cfg_v);
        e      = '0;
        e.poly = c[26:0];
        e.rate = c[28];
        e.mode = c[29];
        n      = e.mode ? 12 : 4;
        for (int i = 0; i < pay_q.size() && i < n; i++) begin
            if (e.mode) e.dec = e.dec | ({prep(pay_q[i]), 352'b0} >> (32 * i));
            else        e.enc = e.enc | ({prep(pay_q[i]), 96'b0} >> (32 * i));
        end
        e.es = (pay_q.size() < n);
        e.el = (pay_q.size() > n);
        exp_q.push_back(e);
        last_exp = e;
    endtask

    // ---------------- driver ----------------
    task automatic send_beat(input logic [31:0] d, input logic last);
        int t;
        int k;
        i_rx_tdata  = d;
        i_rx_tlast  = last;
        i_rx_tvalid = 1'b1;
        t = 0;
        @(negedge sys_clk);
        while (!o_rx_tready) begin
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL tready_timeout actual=0 required=1");
                report_and_finish();
            end
            @(negedge sys_clk);
        end
        @(posedge sys_clk);
        #1;
        i_rx_tvalid = 1'b0;
        i_rx_tlast  = 1'b0;
        if (last) begin
            @(negedge sys_clk);
            chk("valid_latency", 512'(o_frame_valid), 512'(1));
            @(posedge sys_clk);
            #1;
        end
        k = $urandom_range(0, gap_max);
        if (k > 0) begin
            repeat (k) @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_pkt();
        build_expect();
        send_beat(cfg_v, pay_q.size() == 0);
        for (int i = 0; i < pay_q.size(); i++) begin
            send_beat(pay_q[i], i == pay_q.size() - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge sys_clk);
            t++;
        end
        #1;
        chk("queue_drained", 512'(exp_q.size()), 512'(0));
    endtask

    // Downstream ready: random or forced; changes 2 time units after posedge.
    always begin
        @(posedge sys_clk);
        #2;
        i_frame_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge sys_clk) begin
        if (rst) begin
            n_short = 0;
            n_long  = 0;
        end else begin
            if (o_err_short) n_short++;
            if (o_err_long)  n_long++;
            if (o_frame_valid && i_frame_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 512'(1), 512'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("enc_frame", 512'(o_enc_frame), 512'(e.enc));
                    chk("dec_frame", 512'(o_dec_frame), 512'(e.dec));
                    chk("cfg", 512'({o_code_rate, o_mode_sel, o_gen_poly_flat}),
                        512'({e.rate, e.mode, e.poly}));
                    chk("err_short_pulses", 512'(n_short), 512'(e.es));
                    chk("err_long_pulses", 512'(n_long), 512'(e.el));
                end
                n_short = 0;
                n_long  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int bad;
        rst           = 1'b1;
        i_rx_tdata    = '0;
        i_rx_tvalid   = 1'b0;
        i_rx_tlast    = 1'b0;
        i_frame_ready = 1'b0;

        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("reset_tready", 512'(o_rx_tready), 512'(0));
        chk("reset_outputs", 512'({o_frame_valid, o_err_short, o_err_long, o_code_rate,
            o_mode_sel, o_gen_poly_flat}), 512'(0));
        chk("reset_frames", 512'({o_enc_frame, o_dec_frame}), 512'(0));
        chk("reset_state", 512'(o_dbg_state), 512'(0));
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("tready_after_reset", 512'(o_rx_tready), 512'(1));
        @(posedge sys_clk);
        #1;

        // Encode packet
        cfg_v = 32'h1000_0155;
        pay_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        send_pkt();
        // Decode packet
        cfg_v = 32'h2000_0000;
        pay_q.delete();
        for (int i = 0; i < 12; i++) pay_q.push_back(32'hA0 + 32'(i));
        send_pkt();
        // Short packet
        cfg_v = 32'h1000_0155;
        pay_q = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
        send_pkt();
        // Long packet
        pay_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004,
                  32'h0000_0005, 32'h0000_0006};
        send_pkt();
        // Config-only packet
        cfg_v = 32'hC000_0ABC;
        pay_q.delete();
        send_pkt();
        wait_drain();

        // Backpressure: frame held 20 cycles with the next cfg waiting
        ready_force = 1'b0;
        @(posedge sys_clk);
        #3;
        cfg_v = 32'h1000_0155;
        pay_q = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        send_pkt();
        i_rx_tdata  = 32'h1000_0077;
        i_rx_tlast  = 1'b0;
        i_rx_tvalid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (o_rx_tready !== 1'b0 || o_frame_valid !== 1'b1 ||
                o_enc_frame !== last_exp.enc) bad++;
        end
        chk("hold_stable_cycles_bad", 512'(bad), 512'(0));
        ready_force = 1'b1;
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (!o_rx_tready && cyc < 6);
        chk("handoff_tready_cycles", 512'(cyc), 512'(2));
        cfg_v = 32'h1000_0077;
        pay_q = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
        build_expect();
        @(posedge sys_clk);
        #1;
        i_rx_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(pay_q[i], i == 3);
        wait_drain();

        // Mid-packet reset
        send_beat(32'h1000_0155, 1'b0);
        send_beat(32'h5555_5555, 1'b0);
        send_beat(32'h6666_6666, 1'b0);
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("midrst_outputs", 512'({o_rx_tready, o_frame_valid, o_err_short, o_err_long,
            o_code_rate, o_mode_sel, o_gen_poly_flat}), 512'(0));
        chk("midrst_frames", 512'({o_enc_frame, o_dec_frame}), 512'(0));
        rst = 1'b0;
        cfg_v = 32'h2000_0003;
        pay_q.delete();
        pay_q.push_back(32'h4433_2211);
        for (int i = 1; i < 12; i++) pay_q.push_back($urandom);
        send_pkt();
        wait_drain();

        // Randomized packets
        ready_rand = 1'b1;
        gap_max    = 2;
        for (int p = 0; p < 40; p++) begin
            int n;
            cfg_v = $urandom;
            n     = prep(cfg_v) & 32'h2000_0000 ? 12 : 4;
            pay_q.delete();
            for (int i = 0; i < $urandom_range(0, n + 2); i++) pay_q.push_back($urandom);
            send_pkt();
        end
        wait_drain();
        report_and_finish();
    end

endmodule
